// File: rtl/hazard_detection_unit_if.sv
// Signal bundle between the ID-stage pipeline control and the hazard detection unit.
// The master side is the pipeline; the slave side is the hazard unit.
interface hazard_detection_unit_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   i_enable;
    logic [4:0]             i_id_rs;
    logic [4:0]             i_id_rt;
    logic [4:0]             i_ex_rt;
    logic                   i_ex_MemRead;
    logic                   i_branch_taken;
    logic                   o_control_mux;
    logic                   o_pc_write;
    logic                   o_if_id_write;
    logic                   o_if_id_flush;
    logic                   o_id_ex_flush;
    logic                   o_ex_mem_flush;
    logic [COUNT_WIDTH-1:0] o_stall_count;
    logic [COUNT_WIDTH-1:0] o_flush_count;

    modport master (
        output i_enable, i_id_rs, i_id_rt, i_ex_rt, i_ex_MemRead, i_branch_taken,
        input  o_control_mux, o_pc_write, o_if_id_write,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
               o_stall_count, o_flush_count
    );

    modport slave (
        input  i_enable, i_id_rs, i_id_rt, i_ex_rt, i_ex_MemRead, i_branch_taken,
        output o_control_mux, o_pc_write, o_if_id_write,
               o_if_id_flush, o_id_ex_flush, o_ex_mem_flush,
               o_stall_count, o_flush_count
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use bubbles, taken-branch front-end flush,
// and saturating stall/flush event counters for the debug unit.
//
// state      | meaning
// RUN        | normal issue; a load-use hazard here starts a stall window
// LOAD_STALL | remaining bubbles of a multi-cycle load-use stall (counted by remain)
module hazard_detection_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int COUNT_WIDTH  = 16
) (
    input logic                     i_clock,
    input logic                     i_reset,
    hazard_detection_unit_if.slave  bus
);
    localparam int REMAIN_W = $clog2(STALL_CYCLES) + 1;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } state_t;

    state_t                 state, state_next;
    logic [REMAIN_W-1:0]    remain, remain_next;
    logic [COUNT_WIDTH-1:0] stall_count, flush_count;
    logic                   hazard;
    logic                   stall_inc, flush_inc;
    logic                   control_mux, pc_write, if_id_write;
    logic                   if_id_flush, id_ex_flush, ex_mem_flush;

    assign hazard = bus.i_ex_MemRead && (bus.i_ex_rt != 5'd0) &&
                    ((bus.i_ex_rt == bus.i_id_rs) || (bus.i_ex_rt == bus.i_id_rt));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state  <= RUN;
            remain <= '0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    always_comb begin
        state_next   = state;
        remain_next  = remain;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        control_mux  = 1'b1;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (i_reset) begin
            control_mux = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (!bus.i_enable) begin
            // Frozen pipeline: hold everything, still let decoded control through.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (bus.i_branch_taken) begin
            control_mux  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
            state_next   = RUN;
        end else if (state == LOAD_STALL || hazard) begin
            control_mux = 1'b0;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            stall_inc   = 1'b1;
            if (state == LOAD_STALL) begin
                if (remain == REMAIN_W'(1)) begin
                    state_next = RUN;
                end else begin
                    remain_next = remain - REMAIN_W'(1);
                end
            end else if (STALL_CYCLES > 1) begin
                remain_next = REMAIN_W'(STALL_CYCLES - 1);
                state_next  = LOAD_STALL;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && !(&stall_count)) begin
                stall_count <= stall_count + COUNT_WIDTH'(1);
            end
            if (flush_inc && !(&flush_count)) begin
                flush_count <= flush_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_control_mux  = control_mux;
    assign bus.o_pc_write     = pc_write;
    assign bus.o_if_id_write  = if_id_write;
    assign bus.o_if_id_flush  = if_id_flush;
    assign bus.o_id_ex_flush  = id_ex_flush;
    assign bus.o_ex_mem_flush = ex_mem_flush;
    assign bus.o_stall_count  = stall_count;
    assign bus.o_flush_count  = flush_count;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: three instances (1-cycle stall, 3-cycle stall,
// 4-bit counters) share one stimulus stream; each step checks the instance under test.
module tb_hazard_detection_unit;
    localparam int D1  = 1;
    localparam int D3  = 3;
    localparam int DS  = 4;
    localparam logic [5:0] NORM   = 6'b111000;
    localparam logic [5:0] STALL  = 6'b000000;
    localparam logic [5:0] FLUSH  = 6'b011111;
    localparam logic [5:0] FROZEN = 6'b100000;
    localparam logic [5:0] RST    = 6'b000000;

    typedef struct {
        string      tag;
        int         sel;
        logic [5:0] outs;
        int         stall;
        int         flush;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [4:0] rs = '0, rt = '0, xrt = '0;
    logic       mr = 1'b0, br = 1'b0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    hazard_detection_unit_if #(.COUNT_WIDTH(16)) if1 ();
    hazard_detection_unit_if #(.COUNT_WIDTH(16)) if3 ();
    hazard_detection_unit_if #(.COUNT_WIDTH(4))  ifs ();

    assign {if1.i_enable, if1.i_id_rs, if1.i_id_rt, if1.i_ex_rt, if1.i_ex_MemRead, if1.i_branch_taken} = {en, rs, rt, xrt, mr, br};
    assign {if3.i_enable, if3.i_id_rs, if3.i_id_rt, if3.i_ex_rt, if3.i_ex_MemRead, if3.i_branch_taken} = {en, rs, rt, xrt, mr, br};
    assign {ifs.i_enable, ifs.i_id_rs, ifs.i_id_rt, ifs.i_ex_rt, ifs.i_ex_MemRead, ifs.i_branch_taken} = {en, rs, rt, xrt, mr, br};

    hazard_detection_unit #(.STALL_CYCLES(1), .COUNT_WIDTH(16)) u_dut1 (.i_clock(clk), .i_reset(rst), .bus(if1.slave));
    hazard_detection_unit #(.STALL_CYCLES(3), .COUNT_WIDTH(16)) u_dut3 (.i_clock(clk), .i_reset(rst), .bus(if3.slave));
    hazard_detection_unit #(.STALL_CYCLES(1), .COUNT_WIDTH(4))  u_duts (.i_clock(clk), .i_reset(rst), .bus(ifs.slave));

    function automatic logic [5:0] get_outs(input int sel);
        case (sel)
            D1:      return {if1.o_control_mux, if1.o_pc_write, if1.o_if_id_write, if1.o_if_id_flush, if1.o_id_ex_flush, if1.o_ex_mem_flush};
            D3:      return {if3.o_control_mux, if3.o_pc_write, if3.o_if_id_write, if3.o_if_id_flush, if3.o_id_ex_flush, if3.o_ex_mem_flush};
            default: return {ifs.o_control_mux, ifs.o_pc_write, ifs.o_if_id_write, ifs.o_if_id_flush, ifs.o_id_ex_flush, ifs.o_ex_mem_flush};
        endcase
    endfunction

    function automatic int get_stall(input int sel);
        case (sel)
            D1:      return int'(if1.o_stall_count);
            D3:      return int'(if3.o_stall_count);
            default: return int'(ifs.o_stall_count);
        endcase
    endfunction

    function automatic int get_flush(input int sel);
        case (sel)
            D1:      return int'(if1.o_flush_count);
            D3:      return int'(if3.o_flush_count);
            default: return int'(ifs.o_flush_count);
        endcase
    endfunction

    task automatic check_v(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: drive, check Mealy outputs, then counters after the edge.
    task automatic step(input string tag, input int sel, input logic e, input logic [4:0] s_rs, s_rt, s_xrt,
                        input logic s_mr, s_br, input logic [5:0] xo, input int xs, input int xf);
        exp_t       item;
        logic [5:0] got_o;
        en = e; rs = s_rs; rt = s_rt; xrt = s_xrt; mr = s_mr; br = s_br;
        item.tag = tag; item.sel = sel; item.outs = xo; item.stall = xs; item.flush = xf;
        sb.push_back(item);
        #2;
        got_o = get_outs(sel);
        @(posedge clk);
        #1;
        item = sb.pop_front();
        check_v({item.tag, "_outs"}, int'(got_o), int'(item.outs));
        check_v({item.tag, "_stall_count"}, get_stall(item.sel), item.stall);
        check_v({item.tag, "_flush_count"}, get_flush(item.sel), item.flush);
        @(negedge clk);
    endtask

    task automatic s_idle(input string tag, input int sel, input logic [5:0] xo, input int xs, input int xf);
        step(tag, sel, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, xo, xs, xf);
    endtask

    task automatic s_haz(input string tag, input int sel, input logic [5:0] xo, input int xs, input int xf);
        step(tag, sel, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, xo, xs, xf);
    endtask

    // Reset with a live hazard on the inputs; release at the next falling edge with idle inputs.
    task automatic do_reset(input string tag, input int sel);
        rst = 1'b1; en = 1'b1; rs = 5'd5; rt = 5'd0; xrt = 5'd5; mr = 1'b1; br = 1'b0;
        #2;
        check_v({tag, "_rst_outs"}, int'(get_outs(sel)), int'(RST));
        check_v({tag, "_rst_stall"}, get_stall(sel), 0);
        check_v({tag, "_rst_flush"}, get_flush(sel), 0);
        @(negedge clk);
        rst = 1'b0; rs = 5'd0; xrt = 5'd0; mr = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset("init", D1);
        s_idle("rel_norm", D1, NORM, 0, 0);
        s_haz("lu1_rs", D1, STALL, 1, 0);
        s_idle("lu1_after", D1, NORM, 1, 0);
        step("lu1_rt", D1, 1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, STALL, 2, 0);
        s_idle("lu1_after2", D1, NORM, 2, 0);
        step("nomemrd", D1, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, NORM, 2, 0);

        do_reset("lu3", D3);
        s_haz("lu3_c1", D3, STALL, 1, 0);
        s_idle("lu3_c2", D3, STALL, 2, 0);
        s_idle("lu3_c3", D3, STALL, 3, 0);
        s_idle("lu3_done", D3, NORM, 3, 0);
        step("lu3_rt0", D3, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, NORM, 3, 0);
        s_idle("lu3_rt0b", D3, NORM, 3, 0);

        do_reset("br", D3);
        s_haz("br_c1", D3, STALL, 1, 0);
        step("br_abort", D3, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FLUSH, 1, 1);
        s_idle("br_after", D3, NORM, 1, 1);
        step("br_and_h", D3, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, FLUSH, 1, 2);
        s_idle("br_and_h_after", D3, NORM, 1, 2);

        do_reset("frz", D3);
        for (int i = 0; i < 4; i++) begin
            step("frz_hold", D3, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, FROZEN, 0, 0);
        end
        s_haz("frz_c1", D3, STALL, 1, 0);
        s_idle("frz_c2", D3, STALL, 2, 0);
        s_idle("frz_c3", D3, STALL, 3, 0);
        s_idle("frz_done", D3, NORM, 3, 0);

        do_reset("win", D3);
        s_haz("win_c1", D3, STALL, 1, 0);
        step("win_frz", D3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, FROZEN, 1, 0);
        s_idle("win_c2", D3, STALL, 2, 0);
        s_idle("win_c3", D3, STALL, 3, 0);
        s_idle("win_done", D3, NORM, 3, 0);

        do_reset("mid", D3);
        s_haz("mid_c1", D3, STALL, 1, 0);
        do_reset("mid_abort", D3);
        s_idle("mid_after", D3, NORM, 0, 0);
        s_idle("mid_after2", D3, NORM, 0, 0);

        do_reset("sat", DS);
        for (int i = 0; i < 20; i++) begin
            s_haz("sat_hold", DS, STALL, (i + 1 > 15) ? 15 : i + 1, 0);
        end
        s_idle("sat_after", DS, NORM, 15, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
